// File: rtl/alu4_exec_stage.sv
// Execute stage: accepts an operand pair and opcode over valid/ready and computes
// single-cycle ALU ops or a WIDTH-cycle shift-add multiply into registered result/flags.
module alu4_exec_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags,
    output logic                 busy
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CntInit = CW'(WIDTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    // Single-cycle ALU
    logic [WIDTH:0]    sum, diff, shr_ext;
    logic [SW-1:0]     shamt;
    logic [RW-1:0]     alu_res;
    logic              alu_z, alu_c, alu_v, alu_n;

    always_comb begin
        alu_res = '0;
        alu_z   = 1'b0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_n   = 1'b0;
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shamt   = b[SW-1:0];
        // Extra low bit catches the last bit shifted out
        shr_ext = {a, 1'b0} >> shamt;
        case (op)
            3'b000: begin
                alu_res = {{(WIDTH-1){1'b0}}, sum};
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                alu_n   = sum[WIDTH-1];
                alu_z   = (sum[WIDTH-1:0] == '0);
            end
            3'b001: begin
                alu_res = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                alu_n   = diff[WIDTH-1];
                alu_z   = (diff[WIDTH-1:0] == '0);
            end
            3'b010, 3'b011, 3'b100: begin
                if (op == 3'b010) alu_res = {{WIDTH{1'b0}}, a & b};
                else if (op == 3'b011) alu_res = {{WIDTH{1'b0}}, a | b};
                else alu_res = {{WIDTH{1'b0}}, a ^ b};
                alu_n = alu_res[WIDTH-1];
                alu_z = (alu_res == '0);
            end
            3'b101: begin
                alu_res = {{WIDTH{1'b0}}, a} << shamt;
                alu_z   = (alu_res == '0);
            end
            3'b110: begin
                alu_res = {{WIDTH{1'b0}}, shr_ext[WIDTH:1]};
                alu_c   = shr_ext[0];
                alu_z   = (alu_res == '0);
            end
            default: ;
        endcase
    end

    // Shift-add multiply step
    logic [CW-1:0] shift_amt;
    logic [RW-1:0] mul_add, acc_step;

    always_comb begin
        shift_amt = CntInit - cnt_q;
        mul_add   = {{WIDTH{1'b0}}, mcand_q} << shift_amt;
        acc_step  = mplier_q[0] ? acc_q + mul_add : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (ena) begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (op == 3'b111) begin
                            acc_d    = '0;
                            mcand_d  = a;
                            mplier_d = b;
                            cnt_d    = CntInit;
                            state_d  = StMul;
                        end else begin
                            result_d = alu_res;
                            flags_d  = {alu_z, alu_c, alu_v, alu_n};
                            state_d  = StDone;
                        end
                    end
                end
                StMul: begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        result_d = acc_step;
                        flags_d  = {(acc_step == '0), (acc_step[RW-1:WIDTH] != '0), 2'b00};
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // rst_n gating keeps every output at 0 while reset is held
    assign in_ready  = ena && rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StMul);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu4_exec_stage.sv
// Self-checking bench for alu4_exec_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu4_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n, ena, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] a, b, flags;
    logic [2:0] op;
    logic [7:0] result;

    int checks = 0;
    int failures = 0;

    alu4_exec_stage #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed4(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference: plain integer arithmetic, flags packed {Z,C,V,N}
    function automatic void model(input int ma, input int mb, input int mop,
                                  output int res, output int fl);
        int z, c, v, n, s, sh;
        z = 0; c = 0; v = 0; n = 0;
        sh = mb % 4;
        case (mop)
            0: begin
                res = ma + mb;
                c = (res > 15);
                s = to_signed4(ma) + to_signed4(mb);
                v = (s > 7 || s < -8);
                n = ((res % 16) >= 8);
                z = ((res % 16) == 0);
            end
            1: begin
                res = (ma - mb + 16) % 16;
                c = (ma < mb);
                s = to_signed4(ma) - to_signed4(mb);
                v = (s > 7 || s < -8);
                n = (res >= 8);
                z = (res == 0);
            end
            2, 3, 4: begin
                res = (mop == 2) ? (ma & mb) : (mop == 3) ? (ma | mb) : (ma ^ mb);
                n = (res >= 8);
                z = (res == 0);
            end
            5: begin
                res = ma * (2 ** sh);
                z = (res == 0);
            end
            6: begin
                res = ma / (2 ** sh);
                c = (sh == 0) ? 0 : ((ma / (2 ** (sh - 1))) % 2);
                z = (res == 0);
            end
            default: begin
                res = ma * mb;
                c = (res >= 16);
                z = (res == 0);
            end
        endcase
        fl = z * 8 + c * 4 + v * 2 + n;
    endfunction

    task automatic run_op(input int ta, input int tb, input int top, input int hold);
        int er, ef, lat;
        model(ta, tb, top, er, ef);
        a = 4'(ta); b = 4'(tb); op = 3'(top); in_valid = 1'b1;
        chk("in_ready_before_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        a = ~a; b = ~b; op = ~op;
        lat = 1;
        chk("busy_after_accept", busy, (top == 7));
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, (top == 7) ? 5 : 1);
        chk("result", result, er);
        chk("flags", flags, ef);
        chk("busy_in_done", busy, 0);
        chk("in_ready_in_done", in_ready, 0);
        repeat (hold) begin
            a = 4'($urandom_range(0, 15));
            step();
            chk("result_hold", result, er);
            chk("out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_handshake", out_valid, 0);
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    initial begin
        int er, ef, lat, saw;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 4'h9; b = 4'h8; op = 3'b000;
        step();
        step();
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        run_op(4'h9, 4'h8, 0, 0);
        run_op(3, 5, 1, 1);
        run_op(4'hB, 1, 6, 0);
        run_op(15, 15, 7, 0);
        run_op(0, 9, 7, 0);

        // Backpressure with the next op already presented
        model(4'hC, 4'hA, 2, er, ef);
        a = 4'hC; b = 4'hA; op = 3'b010; in_valid = 1'b1;
        step();
        a = 4'h3; b = 4'h4; op = 3'b011;
        chk("bp_out_valid", out_valid, 1);
        repeat (3) begin
            step();
            chk("bp_result_stable", result, er);
            chk("bp_flags_stable", flags, ef);
            chk("bp_no_accept", in_ready, 0);
            chk("bp_out_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_back_to_idle", in_ready, 1);
        step();
        in_valid = 1'b0;
        model(3, 4, 3, er, ef);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, er);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Enable stall during multiply
        a = 4'd7; b = 4'd6; op = 3'b111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        step();
        lat++;
        ena = 1'b0;
        step();
        step();
        lat += 2;
        chk("stall_busy_held", busy, 1);
        chk("stall_no_valid", out_valid, 0);
        ena = 1'b1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("stall_latency", lat, 7);
        chk("stall_result", result, 8'h2A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset pulse mid-multiply discards the operation
        a = 4'd15; b = 4'd15; op = 3'b111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", flags, 0);
        #1;
        rst_n = 1'b1;
        saw = 0;
        repeat (8) begin
            step();
            if (out_valid === 1'b1) saw = 1;
        end
        chk("midrst_no_valid_after", saw, 0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                   $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu4_exec_stage.md
# alu4_exec_stage

Execute stage that sits directly downstream of the 4-bit operand-capture front end. It accepts a latched operand pair and a 3-bit opcode over a valid/ready handshake and computes the result. Single-cycle ops complete in one clock; multiply uses a WIDTH-cycle shift-add sequence. The block holds a registered result plus flags for the output/display stage.

## Interface
- WIDTH, 4, operand width; power of two, ≥ 2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; low freezes all state
- in_valid  in  1  operand/op presented
- in_ready  out  1  stage can accept; = ena && state==IDLE
- a  in  WIDTH  operand A, unsigned / two's complement per op
- b  in  WIDTH  operand B
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- out_valid  out  1  result/flags valid (state==DONE)
- out_ready  in  1  consumer takes result
- result  out  2*WIDTH  registered result
- flags  out  4  {Z, C, V, N}, registered
- busy  out  1  high in MUL state

## Operation
- States: IDLE, MUL, DONE. Reset → IDLE; result, flags, out_valid, busy all 0.
- IDLE: on in_valid && in_ready (accept edge): op≠111 → compute, register result/flags, go DONE; op=111 → load acc=0, mcand=a, mplier=b, cnt=WIDTH, go MUL.
- MUL: each enabled edge: if mplier[0] then acc += mcand << (WIDTH−cnt); mplier >>= 1; cnt−−. On the edge where cnt goes 1→0, register result=acc (final), flags, go DONE.
- DONE: hold result/flags stable; on out_valid && out_ready → IDLE. No bypass: in_ready is 0 in DONE and MUL.
- ena=0: no accept, no iteration, no DONE→IDLE transition; all outputs hold.
- Arithmetic (a,b zero-extended unless stated; result upper bits zero unless stated):
  - ADD: result[WIDTH:0] = a+b; C = carry out; V = signed overflow of WIDTH-bit sum; N = sum[WIDTH−1]; Z = (sum[WIDTH−1:0]==0).
  - SUB: result[WIDTH−1:0] = a−b mod 2^WIDTH; C = borrow (a<b unsigned); V = signed overflow; N = diff[WIDTH−1]; Z on low WIDTH bits.
  - AND/OR/XOR: low WIDTH bits; C=V=0; N = bit WIDTH−1; Z on low WIDTH bits.
  - SHL: result = a << b[log2(WIDTH)−1:0] in 2*WIDTH field (lossless); C=V=N=0; Z on full result.
  - SHR: result = a >> shamt; C = last bit shifted out (0 if shamt=0); V=N=0; Z on full result.
  - MUL: unsigned product, 2*WIDTH bits; C = (result[2W−1:W]≠0); V=N=0; Z on full result.

## Timing
- Non-MUL: accept at edge k → out_valid=1 after edge k (latency 1).
- MUL: accept at edge k → busy=1 after k; out_valid=1 after edge k+WIDTH (latency WIDTH+1 edges from accept, counting the accept edge). busy falls with out_valid rising.
- DONE→IDLE at the handshake edge; earliest next accept is the following edge (throughput: 1 op per 2 cycles, MUL 1 per WIDTH+2).
- result/flags change only on the edge entering DONE; stable throughout DONE regardless of a/b/op.
- rst_n low at any time (incl. mid-MUL or in DONE with out_ready=0): immediate return to IDLE, all outputs 0; the in-flight operation is discarded.

## Test plan
- Reset: rst_n low with in_valid=1 → result=0, flags=0, out_valid=0, busy=0, in_ready=0; after release with ena=1, in_ready=1.
- ADD a=4'h9, b=4'h8 → one edge later out_valid=1, result=8'h11, flags Z=0 C=1 V=1 N=0.
- SUB a=3, b=5 → result=8'h0E, C=1, N=1, V=0, Z=0; SHR a=4'hB, b=1 → result=8'h05, C=1.
- MUL a=15, b=15 → busy=1 for 4 cycles, in_ready=0, out_valid after 5th edge from accept, result=8'hE1, C=1, Z=0; MUL a=0, b=9 → result=0, Z=1.
- Backpressure: AND a=4'hC, b=4'hA with out_ready=0 for 3 cycles, next op held on in_valid → result=8'h08 stable, no accept; out_ready=1 → IDLE, next op accepted on following edge.
- Mid-op events: ena=0 for 2 cycles during MUL 7*6 → latency extends by 2, result=8'h2A; rst_n pulse during MUL → outputs 0, no out_valid.
